// File: rtl/demux_1_16_reg.sv
// demux_1_16_reg: registered 1-to-16 demultiplexer.
// One input word is steered to one of 16 lanes, chosen by an explicit select
// or by an internal round-robin pointer. Each lane has a one-entry holding
// register with its own valid/ready pair, so a stalled lane only blocks
// writes aimed at itself.
module demux_1_16_reg #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    din,
    input  logic [3:0]           sel,
    input  logic                 auto_mode,
    input  logic                 ptr_clr,
    output logic [16*DATA_W-1:0] out_data,
    output logic [15:0]          out_valid,
    input  logic [15:0]          out_ready,
    output logic [3:0]           rr_ptr
);

    logic [15:0][DATA_W-1:0] lane_q;
    logic [15:0]             valid_q;
    logic [3:0]              ptr_q;
    logic [3:0]              tgt;
    logic                    accept;

    // Target lane, input readiness and handshake are purely combinational.
    always_comb begin
        tgt      = auto_mode ? ptr_q : sel;
        in_ready = rst_n & (~valid_q[tgt] | out_ready[tgt]);
        accept   = in_valid & in_ready;
    end

    // Per-lane holding registers: a write wins over a same-cycle drain, so
    // the lane stays valid with the new word and no bubble is inserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int unsigned k = 0; k < 16; k++) begin
                if (accept && (tgt == 4'(k))) begin
                    lane_q[k]  <= din;
                    valid_q[k] <= 1'b1;
                end else if (valid_q[k] && out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: clear has priority over an auto-mode advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (ptr_clr) begin
            ptr_q <= '0;
        end else if (accept && auto_mode) begin
            ptr_q <= ptr_q + 4'd1;
        end
    end

    assign out_data  = lane_q;
    assign out_valid = valid_q;
    assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_demux_1_16_reg.sv
// Self-checking bench for demux_1_16_reg: directed scenarios followed by
// random traffic, all checked against an array-based lane model.
module tb_demux_1_16_reg;

    localparam int DATA_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    din;
    logic [3:0]           sel;
    logic                 auto_mode;
    logic                 ptr_clr;
    logic [16*DATA_W-1:0] out_data;
    logic [15:0]          out_valid;
    logic [15:0]          out_ready;
    logic [3:0]           rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_data  [16];
    bit m_valid [16];
    int m_ptr;

    demux_1_16_reg #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .sel       (sel),
        .auto_mode (auto_mode),
        .ptr_clr   (ptr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_tgt();
        return auto_mode ? m_ptr : int'(sel);
    endfunction

    function automatic bit model_ready();
        int t = model_tgt();
        return rst_n && (!m_valid[t] || out_ready[t]);
    endfunction

    function automatic logic [15:0] model_valid_vec();
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [127:0] model_data_vec();
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++) v[k*DATA_W +: DATA_W] = m_data[k][DATA_W-1:0];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_clock();
        int t;
        bit acc;
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                m_data[k]  = 0;
                m_valid[k] = 0;
            end
            m_ptr = 0;
        end else begin
            t   = model_tgt();
            acc = in_valid && model_ready();
            for (int k = 0; k < 16; k++) begin
                if (m_valid[k] && out_ready[k]) m_valid[k] = 0;
            end
            if (acc) begin
                m_data[t]  = int'(din);
                m_valid[t] = 1;
            end
            if (ptr_clr) m_ptr = 0;
            else if (acc && auto_mode) m_ptr = (m_ptr + 1) % 16;
        end
    endtask

    // One cycle: check in_ready mid-cycle, clock, then check registered outputs.
    task automatic step();
        #4;
        check_eq("in_ready", 128'(in_ready), 128'(model_ready()));
        @(posedge clk);
        model_clock();
        #1;
        check_eq("out_valid", 128'(out_valid), 128'(model_valid_vec()));
        check_eq("out_data", out_data, model_data_vec());
        check_eq("rr_ptr", 128'(rr_ptr), 128'(m_ptr));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            m_data[k]  = 0;
            m_valid[k] = 0;
        end
        m_ptr     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        din       = 8'h3C;
        sel       = 4'd4;
        auto_mode = 1'b0;
        ptr_clr   = 1'b0;
        out_ready = '0;

        // Reset held two cycles with in_valid high
        step();
        step();
        check_eq("reset_in_ready", 128'(in_ready), 128'(0));
        check_eq("reset_valid", 128'(out_valid), 128'(16'h0000));
        check_eq("reset_ptr", 128'(rr_ptr), 128'(0));
        check_eq("reset_data", out_data, 128'(0));

        // Select mode write to lane 9, then stall a second word
        rst_n = 1'b1; sel = 4'd9; din = 8'hA5; in_valid = 1'b1;
        step();
        check_eq("sel9_valid", 128'(out_valid), 128'(16'h0200));
        check_eq("sel9_data", 128'(out_data[9*DATA_W +: DATA_W]), 128'(8'hA5));
        din = 8'hB6;
        step();
        step();
        check_eq("sel9_stall_ready", 128'(in_ready), 128'(0));
        check_eq("sel9_held", 128'(out_data[9*DATA_W +: DATA_W]), 128'(8'hA5));
        out_ready[9] = 1'b1;
        step();
        check_eq("sel9_second", 128'(out_data[9*DATA_W +: DATA_W]), 128'(8'hB6));

        // Round-robin wrap over 18 words
        in_valid = 1'b0; ptr_clr = 1'b1;
        step();
        ptr_clr = 1'b0; auto_mode = 1'b1; out_ready = '1; in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            din = 8'(i);
            step();
        end
        in_valid = 1'b0;
        check_eq("rr_ptr_end", 128'(rr_ptr), 128'(2));
        check_eq("rr_lane0", 128'(out_data[0 +: DATA_W]), 128'(8'h10));
        check_eq("rr_lane1", 128'(out_data[DATA_W +: DATA_W]), 128'(8'h11));
        check_eq("rr_lane15", 128'(out_data[15*DATA_W +: DATA_W]), 128'(8'h0F));

        // Same-lane write and drain in one cycle
        step();
        auto_mode = 1'b0; out_ready = '0; sel = 4'd3; din = 8'h11; in_valid = 1'b1;
        step();
        out_ready[3] = 1'b1; din = 8'h22;
        #4;
        check_eq("wd_in_ready", 128'(in_ready), 128'(1));
        step();
        check_eq("wd_valid3", 128'(out_valid[3]), 128'(1));
        check_eq("wd_data3", 128'(out_data[3*DATA_W +: DATA_W]), 128'(8'h22));

        // Pointer clear with simultaneous auto-mode accept at rr_ptr=7
        in_valid = 1'b0; ptr_clr = 1'b1; out_ready = '1;
        step();
        ptr_clr = 1'b0; auto_mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din = 8'($urandom);
            step();
        end
        check_eq("pre_clr_ptr", 128'(rr_ptr), 128'(7));
        din = 8'h5C; ptr_clr = 1'b1;
        step();
        check_eq("clr_lane7", 128'(out_data[7*DATA_W +: DATA_W]), 128'(8'h5C));
        check_eq("clr_ptr", 128'(rr_ptr), 128'(0));

        // Reset mid-stream with lanes 2 and 5 stalled
        ptr_clr = 1'b0; auto_mode = 1'b0; out_ready = '0;
        sel = 4'd2; din = 8'h77;
        step();
        sel = 4'd5; din = 8'h88;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        check_eq("mid_reset_valid", 128'(out_valid), 128'(0));
        check_eq("mid_reset_ptr", 128'(rr_ptr), 128'(0));
        rst_n = 1'b1; in_valid = 1'b1; sel = 4'd2; din = 8'h99;
        #4;
        check_eq("post_reset_ready", 128'(in_ready), 128'(1));
        step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            din       = 8'($urandom);
            sel       = 4'($urandom);
            auto_mode = $urandom_range(0, 1) != 0;
            ptr_clr   = $urandom_range(0, 9) == 0;
            out_ready = 16'($urandom) & 16'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
